// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data access (DM).
// DM has priority up to DATA_BURST consecutive grants while IF waits; each access ends in a RESP cycle.
module mem_port_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_BURST = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              err
);

  localparam int unsigned BurstW = $clog2(DATA_BURST + 1);
  localparam int unsigned WaitW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [BurstW-1:0] BurstMax = BurstW'(DATA_BURST);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e              state_q, state_d;
  logic [BurstW-1:0]   burst_q, burst_d;
  logic [WaitW-1:0]    wait_q, wait_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d, dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;
  logic                timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    wait_d      = wait_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    if_rdata_d  = '0;
    dm_rdata_d  = '0;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (dm_req && (!if_req || burst_q != BurstMax)) begin
          state_d     = StBusyD;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wait_d      = '0;
          // burst_q < BurstMax here whenever if_req is high, so the increment never wraps
          burst_d     = if_req ? burst_q + BurstW'(1) : '0;
        end else if (if_req) begin
          state_d     = StBusyI;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          wait_d      = '0;
          burst_d     = '0;
        end
      end
      StBusyI, StBusyD: begin
        if (mem_ready || timeout_hit) begin
          state_d     = StResp;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          if (!mem_ready) err_d = 1'b1;
          if (state_q == StBusyI) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            dm_done_d  = 1'b1;
            dm_rdata_d = (mem_ready && !mem_we_q) ? mem_rdata : '0;
          end
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      burst_q     <= '0;
      wait_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      wait_q      <= wait_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = (state_q == StBusyI) || (state_q == StBusyD);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign err       = err_q;
  assign if_stall  = if_req && !if_done_q;
  assign dm_stall  = dm_req && !dm_done_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported instruction/data memory between the fetch stage (IF) and the memory stage (DM) of the pipelined MIPS core. Arbitrates, sequences the memory handshake, returns read data, and drives per-requester stall requests that the hazard logic ORs into StallF/StallD and the M-stage stall. Data accesses take priority, with a burst limit so fetch cannot starve.

## Interface
- DATA_W, 32, data width
- ADDR_W, 32, address width
- DATA_BURST, 4, max consecutive DM grants while IF is pending (≥1)
- TIMEOUT, 16, cycles in BUSY without mem_ready before abort; 0 disables
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held high with stable if_addr until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle completion pulse
- if_rdata  out  DATA_W  fetched word, valid while if_done=1
- if_stall  out  1  if_req && !if_done (combinational)
- dm_req  in  1  data request; held with stable addr/we/wdata until dm_done
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_done  out  1  one-cycle completion pulse
- dm_rdata  out  DATA_W  load data, valid while dm_done=1 (0 for stores)
- dm_stall  out  1  dm_req && !dm_done (combinational)
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE: evaluate requests at clock edge.
  - dm_req only → BUSY_D; if_req only → BUSY_I.
  - Both: BUSY_D unless burst_cnt == DATA_BURST, then BUSY_I.
  - Neither: stay.
- On entry to BUSY_x, register mem_addr/mem_we/mem_wdata from the chosen requester; mem_req=1 throughout BUSY_x. IF grants drive mem_we=0, mem_wdata=0.
- BUSY_x with mem_ready=1 → RESP; capture mem_rdata into x_rdata (dm_rdata=0 when dm_we=1); remember x.
- RESP: x_done=1 for exactly this cycle; mem_req=0; no arbitration → IDLE. RESP exists so requester inputs still held in the done cycle are never re-granted.
- burst_cnt (width clog2(DATA_BURST+1)): +1 on each DM grant made while if_req=1, saturating at DATA_BURST; cleared on any IF grant or whenever a grant is made with if_req=0.
- Timeout: wait_cnt clears on BUSY entry and increments each BUSY cycle without mem_ready. If TIMEOUT≠0 and wait_cnt reaches TIMEOUT-1 without mem_ready: → RESP with rdata=0, set err (cleared only by reset). mem_ready in that same cycle takes precedence (normal completion, no error).
- Outputs not asserted by the current state are 0; rdata outputs are 0 outside RESP.

## Timing
- Reset (async assert, sync release): state=IDLE; mem_req, mem_we, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, err, burst_cnt, wait_cnt all 0. Reset mid-transaction drops mem_req immediately; the in-flight access is discarded with no done.
- Req seen at edge N in IDLE → mem_req high in cycle N+1. Zero-wait memory (mem_ready in N+1) → done in N+2. Each wait cycle adds 1.
- Minimum period between grants: 3 cycles (BUSY, RESP, IDLE).
- The stall outputs are the only combinational paths, input req → stall; all other outputs are registered.
- Requester withdrawing req before done is illegal; behaviour is undefined apart from the FSM always completing the current BUSY/RESP sequence.

## Test plan
- Single load: dm_req=1, dm_we=0, dm_addr=0x40, mem_ready tied 1, mem_rdata=0x1234 → mem_req in cycle 1, dm_done with dm_rdata=0x1234 in cycle 2, dm_stall high in cycles 0–1.
- Simultaneous if_req and dm_req, DATA_BURST=4, dm_req held across 6 back-to-back requests → grant order D,D,D,D,I,D; if_done after the 4th dm_done.
- Store with 3 wait states: dm_we=1, dm_wdata=0xCAFE → mem_we=1, mem_wdata=0xCAFE stable for 4 cycles; dm_done with dm_rdata=0; no re-grant in the RESP cycle.
- Timeout with TIMEOUT=16 and mem_ready held 0 → mem_req high for 16 cycles, then if_done with if_rdata=0 and err=1, with err staying 1 through later successful accesses until rst_n=0.
- rst_n pulsed low while in BUSY_D → mem_req and all outputs go to 0 asynchronously, state returns to IDLE, and no dm_done follows; the next dm_req completes normally.
